// File: rtl/axi_wr_responder.sv
// AXI write-channel responder: queues AW requests, drains W beats into a simple
// backing-store write port and answers on B. Define AXI_WR_PROTOCOL_CHECK_EN for WLAST checking.
module axi_wr_responder #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 32,
  parameter int          AW_DEPTH   = 4,
  parameter int          READY_LAT  = 0,
  parameter logic [31:0] ADDR_LIMIT = 32'h0100_0000
) (
  input  logic                S_AXI_ACLK,
  input  logic                RESET_I,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [7:0]          S_AXI_AWLEN,
  input  logic [1:0]          S_AXI_AWBURST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  output logic [DATA_W/8-1:0] MEM_WSTRB,
  output logic                PROTO_ERR
);

  localparam int                STRB_W     = DATA_W / 8;
  localparam int                PTR_W      = $clog2(AW_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH      = CNT_W'(AW_DEPTH);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);
  localparam logic [ADDR_W-1:0] LIMIT      = ADDR_W'(ADDR_LIMIT);
  localparam logic [3:0]        LAT_INIT   = 4'(READY_LAT);

  typedef enum logic [1:0] {IDLE, LAT, DATA, RESP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
  } aw_entry_t;

  aw_entry_t        aw_mem [AW_DEPTH];
  aw_entry_t        head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             aw_push, aw_pop;

  state_e            state_q, state_d;
  logic [7:0]        beat_q, beat_d, len_q, len_d;
  logic              fixed_q, fixed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        lat_q, lat_d;
  logic              decerr_q, decerr_d, slverr_q, slverr_d, proto_err_q, proto_err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic              wready, bvalid, w_hs, last_beat, wlast_err;

  // Held low through reset so no request is taken while the queue is being flushed.
  assign S_AXI_AWREADY = !RESET_I && (count_q != DEPTH);
  assign aw_push       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign head          = aw_mem[rd_ptr_q];

  assign w_hs      = (state_q == DATA) && S_AXI_WVALID;
  assign last_beat = (beat_q == len_q);

`ifdef AXI_WR_PROTOCOL_CHECK_EN
  assign wlast_err = w_hs && (S_AXI_WLAST != last_beat);
`else
  logic unused_wlast;
  assign unused_wlast = S_AXI_WLAST;
  assign wlast_err    = 1'b0;
`endif

  // NOTE: every signal gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    fixed_d     = fixed_q;
    addr_d      = addr_q;
    lat_d       = lat_q;
    decerr_d    = decerr_q;
    slverr_d    = slverr_q;
    proto_err_d = proto_err_q | wlast_err;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    aw_pop      = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          aw_pop   = 1'b1;
          addr_d   = head.addr;
          len_d    = head.len;
          fixed_d  = (head.burst == 2'b00);
          beat_d   = '0;
          lat_d    = LAT_INIT;
          decerr_d = 1'b0;
          slverr_d = 1'b0;
          state_d  = (READY_LAT > 0) ? LAT : DATA;
        end
      end
      LAT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) state_d = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (!fixed_q) addr_d = addr_q + BEAT_BYTES;
          // Beats past the decode limit are dropped silently and only flagged in BRESP.
          if (addr_q < LIMIT) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = S_AXI_WDATA;
            mem_wstrb_d = S_AXI_WSTRB;
          end else begin
            decerr_d = 1'b1;
          end
          if (wlast_err) slverr_d = 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(aw_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(aw_pop);
    count_d  = count_q + CNT_W'(aw_push) - CNT_W'(aw_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge S_AXI_ACLK) begin
    if (RESET_I) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      fixed_q     <= 1'b0;
      addr_q      <= '0;
      lat_q       <= '0;
      decerr_q    <= 1'b0;
      slverr_q    <= 1'b0;
      proto_err_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      fixed_q     <= fixed_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      decerr_q    <= decerr_d;
      slverr_q    <= slverr_d;
      proto_err_q <= proto_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // NOTE: queue storage is not reset; the pointers and occupancy alone say which entries are live.
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_push) aw_mem[wr_ptr_q] <= '{addr: S_AXI_AWADDR, len: S_AXI_AWLEN, burst: S_AXI_AWBURST};
  end

  assign S_AXI_WREADY = wready;
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = !bvalid  ? 2'b00 :
                        decerr_q ? 2'b11 :
                        slverr_q ? 2'b10 : 2'b00;
  assign MEM_WE       = mem_we_q;
  assign MEM_ADDR     = mem_addr_q;
  assign MEM_WDATA    = mem_wdata_q;
  assign MEM_WSTRB    = mem_wstrb_q;
  assign PROTO_ERR    = proto_err_q;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Self-checking bench for axi_wr_responder: directed and randomized bursts scored against
// a transaction-level model of the expected memory writes and B responses.
module tb_axi_wr_responder;

  localparam logic [31:0] LIMIT = 32'h0000_2000;
`ifdef AXI_WR_PROTOCOL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        awvalid, awready, wvalid, wready, wlast, bvalid, mem_we, proto_err;
  logic [31:0] awaddr, wdata, mem_addr, mem_wdata;
  logic [7:0]  awlen;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb, mem_wstrb;
  logic        bready = 1'b1;

  logic        l_awvalid, l_awready, l_wvalid, l_wready, l_wlast, l_bvalid, l_bready;
  logic        l_mem_we, l_proto_err;
  logic [31:0] l_awaddr, l_wdata, l_mem_addr, l_mem_wdata;
  logic [7:0]  l_awlen;
  logic [1:0]  l_awburst, l_bresp;
  logic [3:0]  l_wstrb, l_mem_wstrb;

  axi_wr_responder #(.DATA_W(32), .ADDR_W(32), .AW_DEPTH(4), .READY_LAT(0), .ADDR_LIMIT(LIMIT)) u_dut (
    .S_AXI_ACLK(clk), .RESET_I(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWBURST(awburst),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WSTRB(mem_wstrb),
    .PROTO_ERR(proto_err)
  );

  axi_wr_responder #(.READY_LAT(3)) u_lat (
    .S_AXI_ACLK(clk), .RESET_I(rst),
    .S_AXI_AWVALID(l_awvalid), .S_AXI_AWREADY(l_awready), .S_AXI_AWADDR(l_awaddr),
    .S_AXI_AWLEN(l_awlen), .S_AXI_AWBURST(l_awburst),
    .S_AXI_WVALID(l_wvalid), .S_AXI_WREADY(l_wready), .S_AXI_WDATA(l_wdata),
    .S_AXI_WSTRB(l_wstrb), .S_AXI_WLAST(l_wlast),
    .S_AXI_BVALID(l_bvalid), .S_AXI_BREADY(l_bready), .S_AXI_BRESP(l_bresp),
    .MEM_WE(l_mem_we), .MEM_ADDR(l_mem_addr), .MEM_WDATA(l_mem_wdata), .MEM_WSTRB(l_mem_wstrb),
    .PROTO_ERR(l_proto_err)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] burst; } burst_t;

  wr_t         exp_wr[$];
  logic [1:0]  exp_b[$];
  burst_t      pend[$];
  int          total = 0;
  int          bad   = 0;
  bit          rand_bready = 1'b0;
  bit          b_prev_hs = 1'b0;
  bit          acc5;
  wr_t         mon_e;
  int          k_cnt, bad_sel;
  logic [31:0] r_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    bready = rand_bready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Memory-write and B-channel scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      b_prev_hs = 1'b0;
    end else begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_mem_we", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_wr.pop_front();
          check("mem_addr", mem_addr, mon_e.addr);
          check("mem_wdata", mem_wdata, mon_e.data);
          check("mem_wstrb", 32'(mem_wstrb), 32'(mon_e.strb));
        end
      end
      if (b_prev_hs) check("bvalid_idle_gap", 32'(bvalid), 32'd0);
      b_prev_hs = bvalid && bready;
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("unexpected_bvalid", 32'(bresp), 32'hFFFF_FFFF);
        else                   check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic push_aw(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    bit acc = 1'b0;
    awaddr  = a;
    awlen   = len;
    awburst = bt;
    awvalid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = awready;
      tick();
    end
    awvalid = 1'b0;
    check("aw_accept", 32'(acc), 32'd1);
    if (acc) pend.push_back('{a, len, bt});
  endtask

  // Sends the data for the oldest pending burst; bad_beat >= 0 inverts WLAST on that beat.
  task automatic send_burst(input int bad_beat, input bit gaps);
    burst_t      b;
    logic [31:0] a;
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    bit          dec = 1'b0;
    bit          hs;
    logic [1:0]  r;
    b = pend.pop_front();
    for (int i = 0; i <= int'(b.len); i++) begin
      a = (b.burst == 2'b00) ? b.addr : b.addr + 32'(i) * 4;
      if (a >= LIMIT) dec = 1'b1;
      dq.push_back($urandom);
      sq.push_back(4'($urandom_range(0, 15)));
    end
    r = dec ? 2'b11 : (CHK_EN && bad_beat >= 0 && bad_beat <= int'(b.len)) ? 2'b10 : 2'b00;
    exp_b.push_back(r);
    for (int i = 0; i <= int'(b.len); i++) begin
      a = (b.burst == 2'b00) ? b.addr : b.addr + 32'(i) * 4;
      if (a < LIMIT) exp_wr.push_back('{a, dq[i], sq[i]});
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      wvalid = 1'b1;
      wdata  = dq[i];
      wstrb  = sq[i];
      wlast  = (i == int'(b.len)) ^ (i == bad_beat);
      hs     = 1'b0;
      for (int n = 0; n < 100 && !hs; n++) begin
        hs = wready;
        tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      check("w_accept", 32'(hs), 32'd1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_b.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_wr", 32'(exp_wr.size()), 32'd0);
    check("drain_b", 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; awlen = '0; awburst = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    l_awvalid = 1'b0; l_awaddr = '0; l_awlen = '0; l_awburst = '0;
    l_wvalid = 1'b0; l_wdata = '0; l_wstrb = '0; l_wlast = 1'b0; l_bready = 1'b0;
    repeat (3) tick();

    check("rst_awready", 32'(awready), 32'd0);
    check("rst_l_awready", 32'(l_awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    #1;
    check("awready_after_rst", 32'(awready), 32'd1);

    // READY_LAT = 3: the pop happens in the cycle after the AW push; WREADY rises 4 cycles later.
    l_awaddr = 32'h200; l_awlen = 8'd0; l_awburst = 2'b01; l_awvalid = 1'b1;
    tick();
    l_awvalid = 1'b0;
    check("lat_wready_pop", 32'(l_wready), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("lat_wready_wait", 32'(l_wready), 32'd0);
    end
    tick();
    check("lat_wready_first", 32'(l_wready), 32'd1);
    l_wdata = 32'hCAFE_0001; l_wstrb = 4'hF; l_wlast = 1'b1; l_wvalid = 1'b1; l_bready = 1'b1;
    tick();
    l_wvalid = 1'b0;
    check("lat_mem_we", 32'(l_mem_we), 32'd1);
    check("lat_mem_addr", l_mem_addr, 32'h200);
    check("lat_mem_wdata", l_mem_wdata, 32'hCAFE_0001);
    check("lat_wready_resp", 32'(l_wready), 32'd0);
    check("lat_bvalid", 32'(l_bvalid), 32'd1);
    check("lat_bresp", 32'(l_bresp), 32'd0);
    tick();
    check("lat_bvalid_done", 32'(l_bvalid), 32'd0);
    check("lat_mem_we_pulse", 32'(l_mem_we), 32'd0);

    // Directed bursts: INCR, FIXED, WRAP-as-INCR, limit edge and address wrap-around.
    push_aw(32'h100, 8'd3, 2'b01);       send_burst(-1, 1'b0); wait_drain();
    push_aw(32'h40, 8'd2, 2'b00);        send_burst(-1, 1'b1); wait_drain();
    push_aw(32'h300, 8'd3, 2'b10);       send_burst(-1, 1'b0);
    push_aw(LIMIT - 32'd4, 8'd1, 2'b01); send_burst(-1, 1'b0);
    push_aw(32'hFFFF_FFF8, 8'd3, 2'b01); send_burst(-1, 1'b0);
    wait_drain();

    // Queue full: one burst stalls in DATA, four more fill the queue, a fifth must wait.
    push_aw(32'h500, 8'd1, 2'b01);
    for (int n = 0; n < 20 && !wready; n++) tick();
    check("stall_wready", 32'(wready), 32'd1);
    awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      awaddr = (k == 1) ? LIMIT : 32'h600 + 32'(k) * 32'h100;
      check("fill_awready", 32'(awready), 32'd1);
      tick();
      pend.push_back('{awaddr, 8'd0, 2'b01});
    end
    check("full_awready", 32'(awready), 32'd0);
    awaddr = LIMIT + 32'h10;
    tick();
    check("full_awready_hold", 32'(awready), 32'd0);
    rand_bready = 1'b1;
    fork
      begin
        acc5 = 1'b0;
        for (int n = 0; n < 200 && !acc5; n++) begin
          acc5 = awready;
          tick();
        end
        awvalid = 1'b0;
        check("aw5_accept", 32'(acc5), 32'd1);
        if (acc5) pend.push_back('{LIMIT + 32'h10, 8'd0, 2'b01});
      end
      send_burst(-1, 1'b1);
    join
    repeat (5) send_burst(-1, 1'b1);
    wait_drain();

    // WLAST on beat 1 of a 4-beat burst.
    push_aw(32'h900, 8'd3, 2'b01); send_burst(1, 1'b0); wait_drain();
    check("proto_err_set", 32'(proto_err), 32'(CHK_EN));
    push_aw(32'h980, 8'd2, 2'b01); send_burst(2, 1'b0); wait_drain();

    // Randomized bursts, up to three AWs queued ahead of their data.
    for (int t = 0; t < 24; t++) begin
      k_cnt = $urandom_range(1, 3);
      for (int j = 0; j < k_cnt; j++) begin
        r_addr = ($urandom_range(0, 3) == 0) ? LIMIT - 32'd32 + 32'(4 * $urandom_range(0, 15))
                                             : 32'(4 * $urandom_range(0, 2047));
        push_aw(r_addr, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
      end
      for (int j = 0; j < k_cnt; j++) begin
        bad_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
        send_burst(bad_sel, 1'b1);
      end
    end
    wait_drain();
    check("proto_err_sticky", 32'(proto_err), 32'(CHK_EN));

    // Reset in the middle of a burst with a second request still queued.
    rand_bready = 1'b0;
    push_aw(32'hA00, 8'd3, 2'b01);
    push_aw(32'hB00, 8'd0, 2'b01);
    pend.delete();
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back('{32'hA00 + 32'(i) * 4, 32'h1111_0000 + 32'(i), 4'hF});
      wvalid = 1'b1; wdata = 32'h1111_0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
      for (int n = 0; n < 20 && !wready; n++) tick();
      tick();
    end
    wvalid = 1'b0;
    tick();
    check("mid_burst_wready", 32'(wready), 32'd1);
    check("mid_burst_wr_seen", 32'(exp_wr.size()), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_mid_wready", 32'(wready), 32'd0);
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check("rst_mid_awready", 32'(awready), 32'd0);
    check("rst_mid_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_wready", 32'(wready), 32'd0);
      check("post_rst_bvalid", 32'(bvalid), 32'd0);
    end
    push_aw(32'hC00, 8'd1, 2'b01); send_burst(-1, 1'b0); wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_responder.md
AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning W/memory data width in bits (32, 64 or 128).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning AXI address width.
REQ-003 SHALL have parameter AW_DEPTH, default 4, meaning address-queue entries (power of 2, 2..16).
REQ-004 SHALL have parameter READY_LAT, default 0, meaning cycles from burst start to first wready (0..15).
REQ-005 SHALL have parameter ADDR_LIMIT, default 32'h0100_0000, meaning first byte address that decodes as invalid.
REQ-006 SHALL have port S_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port RESET_I  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_AWADDR in ADDR_W, S_AXI_AWLEN in 8, S_AXI_AWBURST in 2: write-address channel.
REQ-009 SHALL have ports S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_WDATA in DATA_W, S_AXI_WSTRB in DATA_W/8, S_AXI_WLAST in 1: write-data channel.
REQ-010 SHALL have ports S_AXI_BVALID out 1, S_AXI_BREADY in 1, S_AXI_BRESP out 2: write-response channel.
REQ-011 SHALL have ports MEM_WE out 1, MEM_ADDR out ADDR_W, MEM_WDATA out DATA_W, MEM_WSTRB out DATA_W/8: backing-store write port.
REQ-012 SHALL have port PROTO_ERR  out  1  sticky protocol-error flag.

Function
REQ-013 AW queue SHALL hold {awaddr, awlen, awburst}; S_AXI_AWREADY = 1 while occupancy < AW_DEPTH, else 0.
REQ-014 Push and pop in the same cycle when full SHALL be accepted only if the pop occurs; occupancy never exceeds AW_DEPTH or drops below 0.
REQ-015 FSM states SHALL be IDLE, LAT, DATA, RESP.
REQ-016 IDLE: queue non-empty -> pop head, load beat counter = 0, latency counter = READY_LAT; go to LAT if READY_LAT > 0, else DATA.
REQ-017 LAT: decrement each cycle; enter DATA on the cycle after the counter reaches 0; S_AXI_WREADY = 0.
REQ-018 DATA: S_AXI_WREADY = 1; each WVALID&WREADY beat SHALL increment the beat counter.
REQ-019 Beat address SHALL be burst address + beat x DATA_W/8 for AWBURST 01 (INCR) and for 10 (WRAP, treated as INCR); for 00 (FIXED) it SHALL remain constant; truncate to ADDR_W.
REQ-020 For each accepted beat with beat address < ADDR_LIMIT, MEM_WE SHALL pulse for exactly one cycle, 1 cycle after the handshake, with registered address, data and strobe.
REQ-021 Beats at or above ADDR_LIMIT SHALL suppress MEM_WE and mark the burst DECERR.
REQ-022 The beat where the beat counter equals AWLEN SHALL end DATA and transition to RESP on the next cycle, with S_AXI_WREADY deasserted that cycle.
REQ-023 RESP: S_AXI_BVALID = 1 holding a stable S_AXI_BRESP until BREADY; after the handshake, return to IDLE (no back-to-back BVALID without an IDLE cycle).
REQ-024 BRESP SHALL be 2'b11 if any beat was DECERR, else 2'b10 if a WLAST error occurred (REQ-030), else 2'b00.
REQ-025 A new AW SHALL be accepted in any FSM state if the queue has room.

Reset
REQ-026 While RESET_I = 1 at a clock edge: queue SHALL empty, FSM SHALL go to IDLE, counters SHALL clear.
REQ-027 Reset values SHALL be AWREADY = 0 during reset and 1 on the first cycle after; WREADY = 0, BVALID = 0, BRESP = 00, MEM_WE = 0, MEM_ADDR/WDATA/WSTRB = 0, PROTO_ERR = 0.
REQ-028 Reset mid-burst or mid-response SHALL discard the burst; no MEM_WE or BVALID for it after reset.

Configuration
REQ-029 Macro AXI_WR_PROTOCOL_CHECK_EN SHALL select WLAST checking.
REQ-030 Defined: WLAST = 1 on a non-final beat or WLAST = 0 on the final beat SHALL set PROTO_ERR (sticky until reset) and mark the burst SLVERR; burst length still governed by AWLEN.
REQ-031 Undefined: WLAST SHALL be ignored, PROTO_ERR SHALL be tied 0, and SLVERR SHALL never be issued.

Verification
REQ-032 INCR, addr 0x100, AWLEN 3, DATA_W 32, READY_LAT 0 -> MEM_WE at 0x100/0x104/0x108/0x10C, then one BVALID with BRESP 00.
REQ-033 FIXED, addr 0x40, AWLEN 2 -> three MEM_WE pulses, all at 0x40.
REQ-034 Five back-to-back AWs, AW_DEPTH 4, bursts stalled -> AWREADY low after the 4th push; five B responses in order once data is supplied.
REQ-035 READY_LAT 3 -> WREADY first high exactly 4 cycles after the IDLE pop.
REQ-036 INCR at ADDR_LIMIT-4, AWLEN 1 -> one MEM_WE, second beat suppressed, BRESP 11.
REQ-037 With macro: WLAST on beat 1 of AWLEN 3 -> BRESP 10, PROTO_ERR = 1 until RESET_I; RESET_I mid-burst -> WREADY = 0 and BVALID = 0 next cycle.
